// File: rtl/redmule_pkg.sv
// Shared RedMulE datapath constants. The store packer and the output cast unit
// both derive their narrow-lane geometry from these values.
package redmule_pkg;

  // Full streamer beat width in bits.
  localparam int unsigned DATA_W      = 256;
  // Widest and narrowest element formats handled by the cast unit.
  localparam int unsigned BITW        = 16;
  localparam int unsigned MIN_FMT     = 8;
  // Number of narrow cast beats that fit in one full store beat.
  localparam int unsigned PACK_FACTOR = BITW / MIN_FMT;
  // Useful bits per beat leaving the cast unit when narrowing.
  localparam int unsigned DW_CUT      = DATA_W / PACK_FACTOR;

endpackage : redmule_pkg

// File: rtl/redmule_store_packer.sv
// Output packing stage between the cast unit and the Z store streamer.
// In cast mode it gathers PackFactor narrow beats into one full store beat
// (lane 0 first); otherwise it is a one-deep registered pass-through.
// A flush pushes out a partially filled beat with byte strobes covering only
// the filled lanes and then pulses flush_done_o.
module redmule_store_packer
  import redmule_pkg::*;
#(
  parameter int unsigned DataW      = DATA_W,
  parameter int unsigned PackFactor = PACK_FACTOR
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               cast_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [DataW-1:0]   in_data_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [DataW-1:0]   out_data_o,
  output logic [DataW/8-1:0] out_strb_o,
  output logic               flush_done_o
);

  localparam int unsigned NW = DataW / PackFactor;  // bits per narrow lane
  localparam int unsigned NB = NW / 8;              // bytes per narrow lane
  localparam int unsigned SW = DataW / 8;           // strobe width
  localparam int unsigned CW = $clog2(PackFactor);  // lane counter width
  localparam logic [CW-1:0] LastLane = CW'(PackFactor - 1);

  logic [DataW-1:0] pack_q, pack_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [DataW-1:0] out_data_q, out_data_d;
  logic [SW-1:0]    out_strb_q, out_strb_d;
  logic             flush_pend_q, flush_pend_d;
  logic             flush_done_q, flush_done_d;

  logic             out_free;
  logic             accept;
  logic             load_full;
  logic             flush_act;
  logic [CW-1:0]    cnt_mid;
  logic [DataW-1:0] pack_mid;
  logic [DataW-1:0] part_data;
  logic [SW-1:0]    part_strb;

  // The out register can take a new beat when empty or drained this cycle.
  assign out_free   = !out_valid_q || out_ready_i;
  assign in_ready_o = out_free;
  assign accept     = in_valid_i && in_ready_o;
  // A completing beat (or any pass-through beat) occupies the out register.
  assign load_full  = accept && (!cast_i || (cnt_q == LastLane));
  // A flush raised this cycle is acted on immediately, after the input beat.
  assign flush_act  = flush_pend_q || flush_i;
  // Lane count after this cycle's input beat has been absorbed.
  assign cnt_mid    = (accept && cast_i) ? cnt_q + CW'(1) : cnt_q;

  for (genvar gi = 0; gi < PackFactor; gi++) begin : g_lane
    logic wr_lane;
    logic keep_lane;
    // Write the incoming narrow beat into the lane selected by the counter.
    assign wr_lane   = accept && cast_i && (cnt_q == CW'(gi));
    assign pack_mid[gi*NW +: NW] = wr_lane ? in_data_i[NW-1:0] : pack_q[gi*NW +: NW];
    // For a partial beat only the filled lanes carry data and strobes.
    assign keep_lane = cnt_mid > CW'(gi);
    assign part_data[gi*NW +: NW] = keep_lane ? pack_mid[gi*NW +: NW] : '0;
    assign part_strb[gi*NB +: NB] = {NB{keep_lane}};
  end

  // Next-state logic: input beat first, then flush, with clear overriding all.
  always_comb begin
    pack_d       = pack_mid;
    cnt_d        = cnt_mid;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_strb_d   = out_strb_q;
    flush_pend_d = flush_pend_q;
    flush_done_d = 1'b0;

    if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end

    if (load_full) begin
      out_valid_d = 1'b1;
      out_data_d  = cast_i ? pack_mid : in_data_i;
      out_strb_d  = '1;
    end

    if (flush_act) begin
      flush_pend_d = 1'b1;
      if (load_full) begin
        // The out register was just taken; re-evaluate next cycle.
        flush_pend_d = 1'b1;
      end else if (cnt_mid != '0) begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = part_data;
          out_strb_d  = part_strb;
          cnt_d       = '0;
        end
      end else begin
        flush_done_d = 1'b1;
        flush_pend_d = 1'b0;
      end
    end

    if (clear_i) begin
      cnt_d        = '0;
      out_valid_d  = 1'b0;
      flush_pend_d = 1'b0;
      flush_done_d = 1'b0;
    end
  end

  // State registers; asynchronous reset discards all buffered data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pack_q       <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_strb_q   <= '0;
      flush_pend_q <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      pack_q       <= pack_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_strb_q   <= out_strb_d;
      flush_pend_q <= flush_pend_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign out_strb_o   = out_strb_q;
  assign flush_done_o = flush_done_q;

endmodule : redmule_store_packer

// File: tb/tb_redmule_store_packer.sv
// Directed bench for redmule_store_packer (DataW=256, PackFactor=2).
// Expected store beats are queued as stimulus is driven and compared when
// the DUT hands a beat to the streamer.
`timescale 1ns/1ps
module tb_redmule_store_packer;

  localparam int DW = 256;
  localparam int SW = DW / 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
  } beat_t;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          clear_i;
  logic          cast_i;
  logic          flush_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] out_data_o;
  logic [SW-1:0] out_strb_o;
  logic          flush_done_o;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;
  int cyc = 0;
  beat_t exp_q[$];
  int    pop_cyc[$];
  beat_t mon_e;

  redmule_store_packer #(.DataW(256), .PackFactor(2)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i),
    .cast_i       (cast_i),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_data_i    (in_data_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .out_strb_o   (out_strb_o),
    .flush_done_o (flush_done_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare every beat the streamer takes, and flush completions.
  always @(negedge clk_i) begin
    if (rst_ni && out_valid_o && out_ready_i) begin
      pop_cyc.push_back(cyc);
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_beat observed=%0h expected=none", out_data_o);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        $display("beat data=%0h strb=%0h", out_data_o, out_strb_o);
        chk("out_data", out_data_o, mon_e.d);
        chk("out_strb", DW'(out_strb_o), DW'(mon_e.s));
      end
    end
    if (rst_ni && flush_done_o) begin
      done_seen++;
      $display("flush_done #%0d", done_seen);
      chk("done_after_beats", DW'(exp_q.size()), DW'(0));
    end
  end

  function automatic logic [DW-1:0] rnd256();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [DW-1:0] packed2(input logic [DW-1:0] l1, input logic [DW-1:0] l0);
    return {l1[127:0], l0[127:0]};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [SW-1:0] s);
    beat_t b;
    b.d = d;
    b.s = s;
    exp_q.push_back(b);
  endtask

  // Present one beat and hold it until it is accepted (bounded).
  task automatic send(input logic [DW-1:0] d);
    int n;
    n = 0;
    in_valid_i = 1'b1;
    in_data_i  = d;
    @(negedge clk_i);
    while (!in_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!in_ready_o) chk("send_handshake", DW'(in_ready_o), DW'(1));
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    chk("drain", DW'(exp_q.size()), DW'(0));
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_seen < target && n < 50) begin
      step();
      n++;
    end
    chk("flush_done_cnt", DW'(done_seen), DW'(target));
  endtask

  logic [DW-1:0] va, vb, v0, v1, v2;
  logic [DW-1:0] pt[4];
  int            base;

  initial begin
    rst_ni      = 1'b0;
    clear_i     = 1'b0;
    cast_i      = 1'b0;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    out_ready_i = 1'b1;

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_in_ready", DW'(in_ready_o), DW'(1));
    chk("rst_out_valid", DW'(out_valid_o), DW'(0));
    chk("rst_out_data", out_data_o, '0);
    chk("rst_out_strb", DW'(out_strb_o), DW'(0));
    chk("rst_flush_done", DW'(flush_done_o), DW'(0));
    chk("rst_cnt", DW'(dut.cnt_q), DW'(0));
    step();
    rst_ni = 1'b1;
    step();

    // Two narrow beats pack into one full beat; upper input bits ignored
    cast_i = 1'b1;
    va = {128'h0123456789ABCDEF0123456789ABCDEF, {16{8'hAA}}};
    vb = {128'hFEDCBA9876543210FEDCBA9876543210, {16{8'hBB}}};
    push({{16{8'hBB}}, {16{8'hAA}}}, '1);
    send(va);
    send(vb);
    @(negedge clk_i);
    chk("pack_latency_valid", DW'(out_valid_o), DW'(1));
    step();
    wait_drain();

    // Pass-through, four back-to-back beats
    cast_i = 1'b0;
    step();
    base = pop_cyc.size();
    for (int i = 0; i < 4; i++) begin
      pt[i] = rnd256();
      push(pt[i], '1);
    end
    for (int i = 0; i < 4; i++) send(pt[i]);
    wait_drain();
    for (int i = 0; i < 3; i++) chk("passthru_rate", DW'(pop_cyc[base+i+1] - pop_cyc[base+i]), DW'(1));

    // Three narrow beats then flush: full beat, partial beat, done
    cast_i = 1'b1;
    step();
    v0 = rnd256();
    v1 = rnd256();
    v2 = rnd256();
    push(packed2(v1, v0), '1);
    push({128'h0, v2[127:0]}, 32'h0000FFFF);
    send(v0);
    send(v1);
    send(v2);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    wait_done(1);
    wait_drain();

    // Completing beat and flush in the same cycle: no partial beat
    v0 = rnd256();
    v1 = rnd256();
    push(packed2(v1, v0), '1);
    send(v0);
    in_valid_i = 1'b1;
    in_data_i  = v1;
    flush_i    = 1'b1;
    step();
    in_valid_i = 1'b0;
    flush_i    = 1'b0;
    wait_done(2);
    repeat (3) step();
    chk("no_partial_beat", DW'(exp_q.size()), DW'(0));

    // Back-pressure: out beat held stable, input stalled
    cast_i      = 1'b0;
    out_ready_i = 1'b0;
    step();
    v0 = rnd256();
    v1 = rnd256();
    push(v0, '1);
    push(v1, '1);
    send(v0);
    in_valid_i = 1'b1;
    in_data_i  = v1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("stall_in_ready", DW'(in_ready_o), DW'(0));
      chk("stall_out_valid", DW'(out_valid_o), DW'(1));
      chk("stall_out_data", out_data_o, v0);
      chk("stall_out_strb", DW'(out_strb_o), DW'(32'hFFFF_FFFF));
      step();
    end
    out_ready_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    wait_drain();

    // Clear drops a half-filled beat
    cast_i = 1'b1;
    step();
    send(rnd256());
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    @(negedge clk_i);
    chk("clear_cnt", DW'(dut.cnt_q), DW'(0));
    chk("clear_out_valid", DW'(out_valid_o), DW'(0));
    step();
    v1 = rnd256();
    v2 = rnd256();
    push(packed2(v2, v1), '1);
    send(v1);
    send(v2);
    wait_drain();

    // Asynchronous reset mid-stream with a pending beat
    out_ready_i = 1'b0;
    send(rnd256());
    send(rnd256());
    in_valid_i = 1'b1;
    in_data_i  = rnd256();
    #3;
    rst_ni = 1'b0;
    #1;
    chk("arst_out_valid", DW'(out_valid_o), DW'(0));
    chk("arst_out_data", out_data_o, '0);
    chk("arst_out_strb", DW'(out_strb_o), DW'(0));
    chk("arst_in_ready", DW'(in_ready_o), DW'(1));
    chk("arst_cnt", DW'(dut.cnt_q), DW'(0));
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    step();
    rst_ni = 1'b1;
    step();

    // Flush with nothing buffered: done the cycle after flush_i
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    @(negedge clk_i);
    chk("empty_flush_done", DW'(flush_done_o), DW'(1));
    step();
    @(negedge clk_i);
    chk("done_is_pulse", DW'(flush_done_o), DW'(0));
    chk("total_done", DW'(done_seen), DW'(3));
    chk("final_queue", DW'(exp_q.size()), DW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_redmule_store_packer

// File: doc/redmule_store_packer.md
# redmule_store_packer

Output packing stage directly downstream of the RedMulE output cast unit and upstream of the Z store streamer. When the cast unit narrows results (e.g. FP16 to FP8), each incoming beat carries only DataW/PackFactor useful bits. This block concatenates PackFactor consecutive narrow beats into one full DataW-bit store beat with byte strobes, so memory bandwidth is not wasted. In non-cast mode it is a one-deep registered pass-through.

## Interface
- DataW, default redmule_pkg::DATA_W: full beat width; must be a multiple of 8·PackFactor.
- PackFactor, default redmule_pkg::BITW/redmule_pkg::MIN_FMT: narrow beats per full beat; power of two, ≥2.
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- clear_i  in  1  synchronous clear; drops all buffered state.
- cast_i  in  1  1 = pack narrow beats; 0 = pass through.
- flush_i  in  1  end-of-tile pulse; forces out a partially filled beat.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  input beat accepted when valid&ready.
- in_data_i  in  DataW  beat from cast unit; only bits [NW-1:0] used when cast_i=1 (NW = DataW/PackFactor).
- out_valid_o  out  1  store beat valid.
- out_ready_i  in  1  streamer ready.
- out_data_o  out  DataW  store beat.
- out_strb_o  out  DataW/8  byte strobes.
- flush_done_o  out  1  one-cycle pulse when a flush has completed.

## Operation
- State: pack_q (DataW), cnt_q (log2 PackFactor bits, filled narrow lanes), out register (data/strb/valid), flush_pend_q.
- in_ready_o = !out_valid_o || out_ready_i, regardless of mode; out register frees the cycle it is drained.
- cast_i=0: accepted beat loaded into out register unchanged, strobe all-ones.
- cast_i=1: accepted narrow beat written to lane cnt_q of pack_q (lane k = bits [k·NW +: NW], lane 0 first); cnt_q increments. On the beat making cnt_q wrap from PackFactor-1 to 0, {new lane, pack_q lanes 0..PackFactor-2} loads the out register, strobe all-ones.
- Flush: flush_i sets flush_pend_q. When pending and out register free: if cnt_q>0, emit pack_q with strobes set only for bytes of lanes 0..cnt_q-1, unfilled lanes zero, cnt_q←0; then pulse flush_done_o and clear pending. If cnt_q=0, pulse flush_done_o with no beat emitted.
- Flush and input handshake in same cycle: input beat is processed first; if it completes a full beat, that beat is emitted and the flush finds cnt_q=0 (no partial beat). Flush never overtakes accepted data.
- cast_i is held constant from clear_i until flush_done_o; other behaviour is not specified and not verified.
- clear_i: cnt_q, out_valid_o, flush_pend_q, flush_done_o → 0 next cycle; has priority over all other inputs.

## Timing
- Reset values: in_ready_o=1, out_valid_o=0, out_data_o=0, out_strb_o=0, flush_done_o=0, cnt_q=0.
- Latency: 1 cycle from completing-beat handshake (or pass-through beat) to out_valid_o.
- out_valid_o, out_data_o, out_strb_o stable while out_valid_o && !out_ready_i.
- Sustained throughput: 1 input beat/cycle with out_ready_i=1; 1 output beat per PackFactor inputs in cast mode.
- Flush partial beat appears earliest the cycle after flush_i; flush_done_o pulses the cycle after that beat is loaded (or the cycle after flush_i when nothing is pending).
- Asynchronous reset mid-stream discards all buffered data.

## Structure
- PackFactor derivation (BITW/MIN_FMT) as a localparam in redmule_pkg, shared with the cast unit's DW_CUT.
- Single flat module; no sub-module.

## Test plan
- DataW=256, PackFactor=2, cast_i=1, beats 0xAA.., 0xBB.. (lower 128 bits) -> one out beat {0xBB..,0xAA..}, strb all-ones, 1 cycle after second handshake.
- cast_i=0, 4 back-to-back beats, out_ready_i=1 -> 4 identical out beats, one per cycle, strb all-ones.
- cast_i=1, 3 beats then flush_i -> one full beat, then partial beat: upper 128 bits zero, strb=0x0000FFFF, then flush_done_o.
- Second packing beat handshake and flush_i same cycle -> full beat only, then flush_done_o, no partial beat.
- out_ready_i=0 for 5 cycles with out beat pending -> in_ready_o=0, out data/strb stable; resumes correctly on release.
- One narrow beat accepted, then clear_i -> cnt_q=0; next two beats form a fresh full beat; rst_ni low mid-stream -> all outputs at reset values.
